// File: rtl/sdram_pattern_tester.sv
// sdram_pattern_tester
//   Write/read-back pattern tester for the Apple2e SDRAM on the 14 MHz domain.
//   It writes P(a) to the main bank and ~P(a) to the aux bank for every address
//   in [ADDR_FIRST, ADDR_LAST]. It then reads each location back after READ_LAT
//   cycles and compares both bytes.
//   P(a) = a[7:0] ^ a[15:8] ^ {3'b0, a[20:16]} ^ seed
//
// Optional feature: define SDRAM_PATTERN_LOOP_EN to make the test repeat forever.
//   Each new pass uses the seed incremented by one.
//   mach_done pulses once per pass.
//   The error state accumulates across passes.
//
// Ports
//   clk14M        in   14 MHz clock, rising edge
//   reset14M      in   synchronous active-high reset
//   ready14M      in   SDRAM controller initialised (only looked at while waiting)
//   sdram_dout    in   read data: [7:0] main byte, [15:8] aux byte
//   sdram_addr    out  registered address
//   sdram_din     out  registered write data
//   sdram_we      out  registered write strobe
//   sdram_aux     out  registered bank select (1 = aux)
//   mach_reading  out  read pass in progress
//   mach_error    out  sticky mismatch / illegal-state flag
//   mach_done     out  read pass complete
//   err_count     out  mismatching locations, saturating
//   fail_addr     out  address of the first mismatch
//   fail_data     out  sdram_dout captured at the first mismatch
module sdram_pattern_tester #(
    parameter logic [20:0] ADDR_FIRST = 21'h000000,
    parameter logic [20:0] ADDR_LAST  = 21'h0000FF,
    parameter logic [7:0]  SEED       = 8'hFE,
    parameter int unsigned READ_LAT   = 2,
    parameter int unsigned ERR_CNT_W  = 8
) (
    input  logic                 clk14M,
    input  logic                 reset14M,
    input  logic                 ready14M,
    input  logic [15:0]          sdram_dout,
    output logic [20:0]          sdram_addr,
    output logic [7:0]           sdram_din,
    output logic                 sdram_we,
    output logic                 sdram_aux,
    output logic                 mach_reading,
    output logic                 mach_error,
    output logic                 mach_done,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic [20:0]          fail_addr,
    output logic [15:0]          fail_data
);

    localparam logic [3:0] RL_M1 = 4'(READ_LAT - 1);

    typedef enum logic [2:0] {
        S_WAIT_READY = 3'd0,
        S_WR_MAIN    = 3'd1,
        S_WR_AUX     = 3'd2,
        S_RD_ISSUE   = 3'd3,
        S_RD_WAIT    = 3'd4,
        S_RD_CMP     = 3'd5,
        S_DONE       = 3'd6,
        S_ERR        = 3'd7
    } state_t;

    function automatic logic [7:0] pat(input logic [20:0] a, input logic [7:0] s);
        return a[7:0] ^ a[15:8] ^ {3'b000, a[20:16]} ^ s;
    endfunction

    state_t               state_q, state_d;
    logic [20:0]          cur_q, cur_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [7:0]           seed_d;
    logic [20:0]          addr_q, addr_d;
    logic [7:0]           din_q, din_d;
    logic                 we_q, we_d;
    logic                 aux_q, aux_d;
    logic                 reading_q, reading_d;
    logic                 error_q, error_d;
    logic                 done_q, done_d;
    logic [ERR_CNT_W-1:0] errcnt_q, errcnt_d;
    logic [20:0]          faddr_q, faddr_d;
    logic [15:0]          fdata_q, fdata_d;
    logic [7:0]           p_d;

`ifdef SDRAM_PATTERN_LOOP_EN
    logic [7:0] seed_q;

    always_ff @(posedge clk14M) begin
        if (reset14M) seed_q <= SEED;
        else          seed_q <= seed_d;
    end
`endif

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        cnt_d   = cnt_q;
`ifdef SDRAM_PATTERN_LOOP_EN
        seed_d  = seed_q;
`else
        seed_d  = SEED;
`endif

        // Next state.
        case (state_q)
            S_WAIT_READY: begin
                if (ready14M) begin
                    state_d = S_WR_MAIN;
                    cur_d   = ADDR_FIRST;
                end
            end
            S_WR_MAIN: state_d = S_WR_AUX;
            S_WR_AUX: begin
                if (cur_q == ADDR_LAST) begin
                    cur_d   = ADDR_FIRST;
                    state_d = S_RD_ISSUE;
                end else begin
                    cur_d   = cur_q + 21'd1;
                    state_d = S_WR_MAIN;
                end
            end
            S_RD_ISSUE: begin
                cnt_d   = RL_M1;
                state_d = (READ_LAT == 1) ? S_RD_CMP : S_RD_WAIT;
            end
            S_RD_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) state_d = S_RD_CMP;
            end
            S_RD_CMP: begin
                // The address counter never wraps.
                // The window ends on an equality compare with ADDR_LAST.
                if (cur_q == ADDR_LAST) begin
                    state_d = S_DONE;
                end else begin
                    cur_d   = cur_q + 21'd1;
                    state_d = S_RD_ISSUE;
                end
            end
            S_DONE: begin
`ifdef SDRAM_PATTERN_LOOP_EN
                state_d = S_WR_MAIN;
                cur_d   = ADDR_FIRST;
                seed_d  = seed_q + 8'd1;
`endif
            end
            S_ERR:   state_d = S_ERR;
            default: state_d = S_ERR;
        endcase

        // Registered outputs take the value belonging to the state being entered.
        // Everything below is therefore decoded from state_d / cur_d / seed_d.
        p_d       = pat(cur_d, seed_d);
        addr_d    = addr_q;
        din_d     = 8'h00;
        we_d      = 1'b0;
        aux_d     = 1'b0;
        reading_d = 1'b0;
        done_d    = (state_d == S_DONE);
        error_d   = error_q | (state_d == S_ERR);
        errcnt_d  = errcnt_q;
        faddr_d   = faddr_q;
        fdata_d   = fdata_q;

        case (state_d)
            S_WAIT_READY, S_DONE, S_ERR: addr_d = ADDR_FIRST;
            S_WR_MAIN: begin
                addr_d = cur_d;
                din_d  = p_d;
                we_d   = 1'b1;
            end
            S_WR_AUX: begin
                addr_d = cur_d;
                din_d  = ~p_d;
                aux_d  = 1'b1;
                we_d   = 1'b1;
            end
            S_RD_ISSUE: begin
                addr_d    = cur_d;
                reading_d = 1'b1;
            end
            S_RD_WAIT, S_RD_CMP: reading_d = 1'b1;
            default: ;
        endcase

        // Read data is sampled on the edge that enters RD_CMP.
        // That edge is READ_LAT edges after the address was registered in RD_ISSUE.
        if (state_d == S_RD_CMP && sdram_dout != {~p_d, p_d}) begin
            error_d = 1'b1;
            if (errcnt_q != {ERR_CNT_W{1'b1}}) errcnt_d = errcnt_q + 1'b1;
            // error_q can only be set earlier by a mismatch.
            // The illegal state is terminal, so a clear error_q means this is the first mismatch.
            if (!error_q) begin
                faddr_d = cur_d;
                fdata_d = sdram_dout;
            end
        end
    end

    always_ff @(posedge clk14M) begin
        if (reset14M) begin
            state_q   <= S_WAIT_READY;
            cur_q     <= ADDR_FIRST;
            cnt_q     <= 4'd0;
            addr_q    <= ADDR_FIRST;
            din_q     <= 8'h00;
            we_q      <= 1'b0;
            aux_q     <= 1'b0;
            reading_q <= 1'b0;
            error_q   <= 1'b0;
            done_q    <= 1'b0;
            errcnt_q  <= '0;
            faddr_q   <= 21'd0;
            fdata_q   <= 16'd0;
        end else begin
            state_q   <= state_d;
            cur_q     <= cur_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            din_q     <= din_d;
            we_q      <= we_d;
            aux_q     <= aux_d;
            reading_q <= reading_d;
            error_q   <= error_d;
            done_q    <= done_d;
            errcnt_q  <= errcnt_d;
            faddr_q   <= faddr_d;
            fdata_q   <= fdata_d;
        end
    end

    assign sdram_addr   = addr_q;
    assign sdram_din    = din_q;
    assign sdram_we     = we_q;
    assign sdram_aux    = aux_q;
    assign mach_reading = reading_q;
    assign mach_error   = error_q;
    assign mach_done    = done_q;
    assign err_count    = errcnt_q;
    assign fail_addr    = faddr_q;
    assign fail_data    = fdata_q;

endmodule

// File: doc/sdram_pattern_tester.md
# sdram_pattern_tester

Parametrised write/read-back tester for the Apple2e SDRAM, on the 14 MHz domain. It sits between the board-level start/ready logic and the SDRAM controller's byte port, where it replaces the fixed two-location write/read sequencer. Over a configurable address window it writes a deterministic pattern to the main and aux banks, reads every location back after a configurable latency, and compares both bytes. It reports a sticky error flag, a saturating error count, the first failing address and data, and a completion flag.

## Interface
Parameters:
- ADDR_FIRST, 21'h000000, first address tested (inclusive)
- ADDR_LAST, 21'h0000FF, last address tested (inclusive); must be >= ADDR_FIRST
- SEED, 8'hFE, pattern seed
- READ_LAT, 2, cycles from an address being registered to valid sdram_dout; range 1..15
- ERR_CNT_W, 8, width of err_count

Ports (one clock; reset is synchronous and active-high):
- clk14M  in  1  14 MHz clock; all logic on its rising edge
- reset14M  in  1  synchronous active-high reset
- ready14M  in  1  SDRAM controller initialised; sampled only in WAIT_READY
- sdram_dout  in  16  read data: [7:0] main byte, [15:8] aux byte
- sdram_addr  out  21  registered address
- sdram_din  out  8  registered write data
- sdram_we  out  1  registered write strobe
- sdram_aux  out  1  registered bank select (1 = aux)
- mach_reading  out  1  high during the read pass
- mach_error  out  1  sticky: any mismatch or illegal state
- mach_done  out  1  high once the read pass completes
- err_count  out  ERR_CNT_W  mismatching locations, saturating at all-ones
- fail_addr  out  21  address of the first mismatch
- fail_data  out  16  sdram_dout captured at the first mismatch

## Operation
- Pattern: P(a) = a[7:0] ^ a[15:8] ^ {3'b0, a[20:16]} ^ SEED. Main byte = P(a); aux byte = ~P(a).
- States: WAIT_READY, WR_MAIN, WR_AUX, RD_ISSUE, RD_WAIT, RD_CMP, DONE, ERR.
- WAIT_READY: outputs idle (we=0, aux=0, din=0, addr=ADDR_FIRST). If ready14M is high, go to WR_MAIN with cur=ADDR_FIRST.
- WR_MAIN: drive addr=cur, aux=0, din=P(cur), we=1. Then go to WR_AUX.
- WR_AUX: drive addr=cur, aux=1, din=~P(cur), we=1. If cur==ADDR_LAST, set cur=ADDR_FIRST and go to RD_ISSUE; otherwise increment cur and go to WR_MAIN.
- RD_ISSUE: drive addr=cur, aux=0, din=0, we=0, and raise mach_reading. Load the wait counter with READ_LAT-1, then go to RD_WAIT, or straight to RD_CMP if READ_LAT==1.
- RD_WAIT: decrement the counter; go to RD_CMP when it reaches 0.
- RD_CMP: compare sdram_dout against {~P(cur), P(cur)}.
  - On mismatch: set mach_error and increment err_count (saturating).
  - If this is the first mismatch since reset, latch fail_addr=cur and fail_data=sdram_dout.
  - Then, if cur==ADDR_LAST, go to DONE; otherwise increment cur and go to RD_ISSUE.
- DONE: raise mach_done, drop mach_reading, drive idle outputs; hold until reset.
- ERR (any unencoded state): set mach_error, drive idle outputs, hold until reset.
- ready14M is ignored outside WAIT_READY. Deassertion mid-run has no effect.
- The address counter is 21 bits. ADDR_LAST = 21'h1FFFFF terminates by equality compare, never by wrap.

## Timing
- Reset (sampled on a rising edge) forces on the next edge:
  - state WAIT_READY
  - sdram_we=0, sdram_aux=0, sdram_din=0, sdram_addr=ADDR_FIRST
  - mach_reading=0, mach_error=0, mach_done=0, err_count=0, fail_addr=0, fail_data=0
- Reset mid-write drops sdram_we on that same edge. No further write is issued.
- All outputs are registered. Values set "in" a state appear on the edge that enters that state.
- sdram_dout is sampled on the edge exactly READ_LAT cycles after the edge that registered the address in RD_ISSUE.
- With N = ADDR_LAST-ADDR_FIRST+1:
  - the write pass takes 2N cycles
  - the read pass takes N*(READ_LAT+1) cycles
  - mach_done rises 1 cycle after the last RD_CMP
- The first write strobe is registered 1 edge after ready14M is sampled high.

## Configuration
- SDRAM_PATTERN_LOOP_EN defined:
  - DONE is not terminal. From DONE the block re-enters WR_MAIN with cur=ADDR_FIRST and an internal seed incremented by 1 (mod 256).
  - mach_done pulses high for 1 cycle per completed pass.
  - mach_error, err_count and fail_* accumulate across passes and clear only on reset.
- Undefined: single pass with seed fixed at SEED; DONE holds until reset.

## Test plan
- Ideal SDRAM model (READ_LAT=2), ADDR_FIRST=0, ADDR_LAST=3, ready14M high after reset -> 8 write strobes (main/aux pairs: FE/01, FF/00, FC/03, FD/02), mach_done after 2*4+4*3+1 cycles, mach_error=0, err_count=0.
- Model flips aux bit 0 at address 2 -> mach_error=1, err_count=1, fail_addr=21'h000002, fail_data=16'h02FC, mach_done=1.
- Stuck-at-zero model, ADDR_LAST=21'h0003FF, ERR_CNT_W=8 -> err_count saturates at 8'hFF, fail_addr=0, fail_data=16'h0000.
- ready14M held low for 50 cycles -> sdram_we stays 0 and state remains WAIT_READY; the first strobe appears 1 edge after ready14M rises.
- reset14M asserted during the 3rd WR_AUX -> sdram_we=0 on the next edge; all outputs at reset values; the full pass reruns cleanly after release.
- With SDRAM_PATTERN_LOOP_EN, N=4 -> mach_done pulses once per pass; the second pass writes main byte FF at address 0 (seed FF).
